// File: rtl/axis_synchronizer_2.sv
// Two-channel AXI-Stream joiner: per-channel 2-deep FIFOs feed one
// registered output stage that emits channel pairs in arrival order.

module axis_sync_fifo #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic         pop,
   output logic         not_empty,
   output logic [W-1:0] head
);

   logic [W-1:0] mem [2];
   logic         wp;
   logic         rp;
   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   logic         push;

   assign push      = in_valid & in_ready;
   assign cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};
   assign not_empty = (cnt != 2'd0);
   assign head      = mem[rp];

   // ready reflects occupancy after this edge, so it never admits a third word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wp       <= 1'b0;
         rp       <= 1'b0;
         cnt      <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wp] <= in_data;
            wp      <= ~wp;
         end
         if (pop) begin
            rp <= ~rp;
         end
         cnt      <= cnt_nxt;
         in_ready <= (cnt_nxt < 2'd2);
      end
   end

endmodule

module axis_synchronizer_2 #(
   parameter int DATA_WIDTH_0 = 16,
   parameter int DATA_WIDTH_1 = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    input_0_valid,
   input  logic [DATA_WIDTH_0-1:0] input_0_data,
   output logic                    input_0_ready,
   input  logic                    input_1_valid,
   input  logic [DATA_WIDTH_1-1:0] input_1_data,
   output logic                    input_1_ready,
   output logic                    output_valid,
   output logic [DATA_WIDTH_0-1:0] output_data_0,
   output logic [DATA_WIDTH_1-1:0] output_data_1,
   input  logic                    output_ready
);

   logic                    ne_0;
   logic                    ne_1;
   logic [DATA_WIDTH_0-1:0] head_0;
   logic [DATA_WIDTH_1-1:0] head_1;
   logic                    load;

   assign load = ne_0 & ne_1 & (~output_valid | output_ready);

   axis_sync_fifo #(.W(DATA_WIDTH_0)) u_fifo_0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (input_0_valid),
      .in_data   (input_0_data),
      .in_ready  (input_0_ready),
      .pop       (load),
      .not_empty (ne_0),
      .head      (head_0)
   );

   axis_sync_fifo #(.W(DATA_WIDTH_1)) u_fifo_1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (input_1_valid),
      .in_data   (input_1_data),
      .in_ready  (input_1_ready),
      .pop       (load),
      .not_empty (ne_1),
      .head      (head_1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         output_valid  <= 1'b0;
         output_data_0 <= '0;
         output_data_1 <= '0;
      end else if (load) begin
         output_valid  <= 1'b1;
         output_data_0 <= head_0;
         output_data_1 <= head_1;
      end else if (output_ready) begin
         output_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_synchronizer_2.sv
// Directed bench for axis_synchronizer_2 with an arrival-order
// pairing model checked on every consumed output pair.

module tb_axis_synchronizer_2;

   logic        clk;
   logic        rst;
   logic        v0;
   logic [15:0] d0_in;
   logic        r0;
   logic        v1;
   logic [15:0] d1_in;
   logic        r1;
   logic        ov;
   logic [15:0] od0;
   logic [15:0] od1;
   logic        ordy;

   int checks;
   int errors;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   bit auto0;
   bit auto1;
   logic [15:0] k;

   axis_synchronizer_2 #(
      .DATA_WIDTH_0(16),
      .DATA_WIDTH_1(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .input_0_valid (v0),
      .input_0_data  (d0_in),
      .input_0_ready (r0),
      .input_1_valid (v1),
      .input_1_data  (d1_in),
      .input_1_ready (r1),
      .output_valid  (ov),
      .output_data_0 (od0),
      .output_data_1 (od1),
      .output_ready  (ordy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: score consumed pair, log accepted words, advance edge
   task automatic tick();
      logic a0;
      logic a1;
      logic cs;
      a0 = v0 & r0;
      a1 = v1 & r1;
      cs = ov & ordy;
      if (cs) begin
         chk("pair_expected", {31'd0, (q0.size() != 0 && q1.size() != 0)}, 32'd1);
         if (q0.size() != 0 && q1.size() != 0) begin
            chk("pair_d0", {16'd0, od0}, {16'd0, q0[0]});
            chk("pair_d1", {16'd0, od1}, {16'd0, q1[0]});
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
      end
      if (a0) q0.push_back(d0_in);
      if (a1) q1.push_back(d1_in);
      @(posedge clk);
      #1;
      if (a0 && auto0) d0_in = d0_in + 16'd1;
      if (a1 && auto1) d1_in = d1_in + 16'd1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      auto0 = 0;
      auto1 = 0;
      v0 = 0;
      v1 = 0;
      d0_in = '0;
      d1_in = '0;
      ordy = 0;
      rst = 1;
      #2;
      rst = 0;
      tick();
      tick();
      chk("rst_ov", {31'd0, ov}, 32'd0);
      chk("rst_d0", {16'd0, od0}, 32'd0);
      chk("rst_d1", {16'd0, od1}, 32'd0);
      chk("rst_r0", {31'd0, r0}, 32'd0);
      chk("rst_r1", {31'd0, r1}, 32'd0);

      rst = 1;
      tick();
      chk("rel_r0", {31'd0, r0}, 32'd1);
      chk("rel_r1", {31'd0, r1}, 32'd1);

      // counter streaming
      ordy = 1;
      v0 = 1;
      v1 = 1;
      auto0 = 1;
      auto1 = 1;
      tick();
      chk("lat_ov0", {31'd0, ov}, 32'd0);
      tick();
      chk("lat_ov1", {31'd0, ov}, 32'd1);
      chk("first_d0", {16'd0, od0}, 32'd0);
      chk("first_d1", {16'd0, od1}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("tput_ov", {31'd0, ov}, 32'd1);
         chk("tput_r0", {31'd0, r0}, 32'd1);
         chk("tput_d0", {16'd0, od0}, i + 1);
      end

      // downstream stall for 5 cycles
      k = od0;
      ordy = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("stall_ov", {31'd0, ov}, 32'd1);
      chk("stall_d0", {16'd0, od0}, {16'd0, k});
      chk("stall_d1", {16'd0, od1}, {16'd0, k});
      chk("stall_r0", {31'd0, r0}, 32'd0);
      chk("stall_r1", {31'd0, r1}, 32'd0);
      chk("stall_next0", {16'd0, d0_in}, {16'd0, k} + 32'd3);
      chk("stall_next1", {16'd0, d1_in}, {16'd0, k} + 32'd3);
      ordy = 1;
      for (int i = 0; i < 6; i++) tick();
      v0 = 0;
      v1 = 0;
      auto0 = 0;
      auto1 = 0;
      for (int i = 0; i < 6; i++) tick();
      chk("drain1_ov", {31'd0, ov}, 32'd0);
      chk("drain1_q", q0.size() + q1.size(), 32'd0);

      // only channel 0 offers two words
      v0 = 1;
      d0_in = 16'h0005;
      tick();
      d0_in = 16'h0006;
      tick();
      v0 = 0;
      chk("solo_r0", {31'd0, r0}, 32'd0);
      chk("solo_ov", {31'd0, ov}, 32'd0);
      v1 = 1;
      d1_in = 16'h0100;
      tick();
      v1 = 0;
      tick();
      chk("solo_pov", {31'd0, ov}, 32'd1);
      chk("solo_pd0", {16'd0, od0}, 32'h0005);
      chk("solo_pd1", {16'd0, od1}, 32'h0100);
      v1 = 1;
      d1_in = 16'h0101;
      tick();
      v1 = 0;
      tick();
      chk("solo2_d0", {16'd0, od0}, 32'h0006);
      chk("solo2_d1", {16'd0, od1}, 32'h0101);
      for (int i = 0; i < 3; i++) tick();
      chk("drain2_q", q0.size() + q1.size(), 32'd0);

      // alternating channel activity
      for (int i = 0; i < 8; i++) begin
         v0 = (i % 2 == 0);
         v1 = (i % 2 == 1);
         d0_in = 16'h0010 + 16'(i);
         d1_in = 16'h0020 + 16'(i);
         tick();
      end
      v0 = 0;
      v1 = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("alt_ov", {31'd0, ov}, 32'd0);
      chk("alt_q", q0.size() + q1.size(), 32'd0);

      // reset with buffered words and a held output
      ordy = 0;
      v0 = 1;
      v1 = 1;
      d0_in = 16'h0077;
      d1_in = 16'h0088;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_ov", {31'd0, ov}, 32'd1);
      chk("pre_rst_r0", {31'd0, r0}, 32'd0);
      v0 = 0;
      v1 = 0;
      rst = 0;
      #1;
      chk("async_ov", {31'd0, ov}, 32'd0);
      chk("async_d0", {16'd0, od0}, 32'd0);
      chk("async_d1", {16'd0, od1}, 32'd0);
      chk("async_r0", {31'd0, r0}, 32'd0);
      chk("async_r1", {31'd0, r1}, 32'd0);
      q0.delete();
      q1.delete();
      tick();
      rst = 1;
      tick();
      ordy = 1;
      v0 = 1;
      v1 = 1;
      d0_in = 16'h00A1;
      d1_in = 16'h00B1;
      tick();
      v0 = 0;
      v1 = 0;
      tick();
      chk("new_ov", {31'd0, ov}, 32'd1);
      chk("new_d0", {16'd0, od0}, 32'h00A1);
      chk("new_d1", {16'd0, od1}, 32'h00B1);
      for (int i = 0; i < 3; i++) tick();
      chk("end_ov", {31'd0, ov}, 32'd0);
      chk("end_q", q0.size() + q1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_synchronizer_2.md
AXIS_SYNCHRONIZER_2 -- requirements
Module: axis_synchronizer_2

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH_0, default 16, giving the bit width of input channel 0 data.
REQ-002 The module SHALL have parameter DATA_WIDTH_1, default 16, giving the bit width of input channel 1 data.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port input_0_valid, input, 1 bit: channel 0 word offered.
REQ-006 The module SHALL have port input_0_data, input, DATA_WIDTH_0 bits: channel 0 payload.
REQ-007 The module SHALL have port input_0_ready, output, 1 bit: channel 0 can accept a word.
REQ-008 The module SHALL have port input_1_valid, input, 1 bit: channel 1 word offered.
REQ-009 The module SHALL have port input_1_data, input, DATA_WIDTH_1 bits: channel 1 payload.
REQ-010 The module SHALL have port input_1_ready, output, 1 bit: channel 1 can accept a word.
REQ-011 The module SHALL have port output_valid, output, 1 bit: joined pair available.
REQ-012 The module SHALL have port output_data_0, output, DATA_WIDTH_0 bits: channel 0 half of the pair.
REQ-013 The module SHALL have port output_data_1, output, DATA_WIDTH_1 bits: channel 1 half of the pair.
REQ-014 The module SHALL have port output_ready, input, 1 bit: downstream accepts the pair.

Function
REQ-015 A transfer on any port SHALL occur only on a rising edge where the port's valid and ready are both 1.
REQ-016 Each input channel SHALL have an independent 2-entry FIFO (skid buffer) that stores accepted words in order.
REQ-017 input_x_ready SHALL be a registered signal equal to 1 exactly when channel x's FIFO holds fewer than 2 words after the current edge's push/pop.
REQ-018 input_x_ready SHALL NOT depend combinationally on output_ready or on the other channel.
REQ-019 The output stage SHALL be a single register holding output_valid, output_data_0 and output_data_1.
REQ-020 The output register SHALL load when both FIFOs are non-empty and either output_valid=0 or output_ready=1.
REQ-021 On each load, the output register SHALL pop one word from each FIFO simultaneously, and the popped heads SHALL appear together as output_data_0/output_data_1.
REQ-022 When output_ready=1 and no load occurs, output_valid SHALL clear to 0.
REQ-023 When output_valid=1 and output_ready=0, output_valid and both output data fields SHALL hold stable.
REQ-024 Pairing SHALL be strictly by arrival order: the k-th word accepted on channel 0 is always emitted with the k-th word accepted on channel 1.
REQ-025 Latency SHALL be 1 cycle: a word accepted at edge N appears on the output after edge N+1, provided its partner is present and the output register is free.
REQ-026 With both inputs continuously valid and output_ready=1, the module SHALL sustain one pair per cycle.
REQ-027 A channel whose partner is absent SHALL buffer up to 2 words, then deassert its ready; no word SHALL be dropped or duplicated.
REQ-028 A FIFO SHALL allow a push and a pop on the same edge, with the count unchanged.
REQ-029 No push SHALL occur on a full FIFO, and no pop SHALL occur on an empty FIFO.
REQ-030 Data SHALL pass through unmodified, with no width conversion.

Reset
REQ-031 While rst=0, FIFOs SHALL empty, output_valid=0, output data=0, and input_0_ready=input_1_ready=0.
REQ-032 The first rising edge after rst goes high SHALL set input_0_ready=input_1_ready=1.
REQ-033 Asserting reset mid-operation SHALL discard all buffered and output-held words immediately.

Verification
REQ-034 Both inputs supply counter words 0,1,2,... continuously with output_ready=1 -> pairs (0,0),(1,1),(2,2)... emitted one per cycle, first pair one cycle after first acceptance.
REQ-035 output_ready=0 for 5 cycles during streaming -> output holds its pair, each input accepts exactly 2 further words then ready=0, and on resume the sequence continues with no gap or duplicate.
REQ-036 Only channel 0 is valid, with words 0x0005 and 0x0006 -> both accepted, input_0_ready=0, output_valid=0; then channel 1 sends 0x0100 -> output (0x0005,0x0100).
REQ-037 Channels are valid on alternating cycles -> pairing still follows arrival order and no word is lost.
REQ-038 Reset asserted with 2 words buffered and output_valid=1 -> all outputs go to 0 immediately; after release the first pair is built from new words only.
